// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory op at a time, drives the data memory for one cycle, returns a response.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned H/HU/W accesses as invalid ops.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_load_code,
  output logic [1:0]  mem_store_code,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned FW = 3;
  localparam int unsigned SW = 2;

  localparam logic [FW-1:0] LD_IDLE = 3'b111;
  localparam logic [SW-1:0] ST_IDLE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          load_q, load_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          err_q, err_d;
  logic [FW-1:0] ld_code_q, ld_code_d;
  logic [SW-1:0] st_code_q, st_code_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic          op_bad_c;

  // Reject unsupported size codes (and misaligned accesses when trapping is enabled)
  always_comb begin
    op_bad_c = 1'b0;
    if (req_load) begin
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
        op_bad_c = 1'b1;
    end else begin
      if (req_funct3 != 3'b000 && req_funct3 != 3'b001 && req_funct3 != 3'b010)
        op_bad_c = 1'b1;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      op_bad_c = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      op_bad_c = 1'b1;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    load_d    = load_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    err_d     = err_q;
    ld_code_d = LD_IDLE;
    st_code_d = ST_IDLE;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          load_d  = req_load;
          rd_d    = req_load ? req_rd : RW'(0);
          rdata_d = DW'(0);
          if (op_bad_c) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            if (req_load) ld_code_d = req_funct3;
            else          st_code_d = req_funct3[1:0];
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        rdata_d = load_q ? mem_rdata : DW'(0);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= AW'(0);
      wdata_q   <= DW'(0);
      load_q    <= 1'b0;
      rdata_q   <= DW'(0);
      rd_q      <= RW'(0);
      err_q     <= 1'b0;
      ld_code_q <= LD_IDLE;
      st_code_q <= ST_IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      load_q    <= load_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      ld_code_q <= ld_code_d;
      st_code_q <= st_code_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
    end
  end

  assign req_ready      = ready_q;
  assign rsp_valid      = valid_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_rd         = rd_q;
  assign rsp_err        = err_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_load_code  = ld_code_q;
  assign mem_store_code = st_code_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small byte-addressed data memory model that performs load extension.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_load_code;
  logic [1:0]  mem_store_code;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  int compared   = 0;
  int mismatched = 0;
  int acc_cnt    = 0;
  int acc_base;

  logic [7:0]  mem [0:255];
  logic [7:0]  ma;
  logic [31:0] mw;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_load_code(mem_load_code),
    .mem_store_code(mem_store_code), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Memory read path with sign/zero extension, little endian
  always_comb begin
    ma = mem_addr[7:0];
    mw = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    case (mem_load_code)
      3'b000:  mem_rdata = {{24{mw[7]}}, mw[7:0]};
      3'b001:  mem_rdata = {{16{mw[15]}}, mw[15:0]};
      3'b010:  mem_rdata = mw;
      3'b100:  mem_rdata = {24'h0, mw[7:0]};
      3'b101:  mem_rdata = {16'h0, mw[15:0]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      case (mem_store_code)
        2'b00: mem[mem_addr[7:0]] <= mem_wdata[7:0];
        2'b01: begin
          mem[mem_addr[7:0]]         <= mem_wdata[7:0];
          mem[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
        end
        2'b10: begin
          mem[mem_addr[7:0]]         <= mem_wdata[7:0];
          mem[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
          mem[mem_addr[7:0] + 8'd2]  <= mem_wdata[23:16];
          mem[mem_addr[7:0] + 8'd3]  <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_load_code != 3'b111 || mem_store_code != 2'b11) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_load   = ld;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; rsp_ready = 1'b1;
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ld_code", 32'(mem_load_code), 32'h7);
    chk("rst_st_code", 32'(mem_store_code), 32'h3);
    rst = 1'b0;
    step();

    // SW 0x10 then LW 0x10
    set_req(1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 5'd4);
    step();
    req_valid = 1'b0;
    chk("sw_issue_st_code", 32'(mem_store_code), 32'h2);
    chk("sw_issue_ld_code", 32'(mem_load_code), 32'h7);
    chk("sw_issue_addr", mem_addr, 32'h10);
    chk("sw_issue_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_issue_req_ready", 32'(req_ready), 32'd0);
    chk("sw_issue_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sw_rsp_err", 32'(rsp_err), 32'd0);
    chk("sw_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("sw_rsp_rdata", rsp_rdata, 32'h0);
    chk("sw_rsp_st_code_idle", 32'(mem_store_code), 32'h3);
    step();
    chk("sw_done_req_ready", 32'(req_ready), 32'd1);
    chk("sw_done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_addr_held", mem_addr, 32'h10);

    set_req(1'b1, 3'b010, 32'h10, 32'h0, 5'd5);
    step();
    req_valid = 1'b0;
    chk("lw_issue_ld_code", 32'(mem_load_code), 32'h2);
    chk("lw_issue_st_code", 32'(mem_store_code), 32'h3);
    step();
    chk("lw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("lw_rsp_rd", 32'(rsp_rd), 32'd5);
    chk("lw_rsp_err", 32'(rsp_err), 32'd0);
    step();

    // LB passes sign-extended data from memory unchanged
    set_req(1'b1, 3'b000, 32'h10, 32'h0, 5'd6);
    step();
    req_valid = 1'b0;
    step();
    chk("lb_rsp_rdata", rsp_rdata, 32'hFFFFFFEF);
    step();

    // Two stores with stalled responses
    rsp_ready = 1'b0;
    set_req(1'b0, 3'b000, 32'h20, 32'h11223344, 5'd0);
    step();
    set_req(1'b0, 3'b000, 32'h20, 32'h55667788, 5'd0);
    chk("sb1_issue_st_code", 32'(mem_store_code), 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb1_stall_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("sb1_stall_ready_%0d", i), 32'(req_ready), 32'd0);
      chk($sformatf("sb1_stall_err_%0d", i), 32'(rsp_err), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("sb1_hs_req_ready", 32'(req_ready), 32'd1);
    chk("sb1_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("sb1_hs_no_issue", 32'(mem_store_code), 32'h3);
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    chk("sb2_issue_st_code", 32'(mem_store_code), 32'h0);
    chk("sb2_issue_wdata", mem_wdata, 32'h55667788);
    step();
    chk("sb2_stall_valid_a", 32'(rsp_valid), 32'd1);
    step();
    chk("sb2_stall_valid_b", 32'(rsp_valid), 32'd1);
    chk("sb2_stall_ld_code", 32'(mem_load_code), 32'h7);
    rsp_ready = 1'b1;
    step();
    set_req(1'b1, 3'b100, 32'h20, 32'h0, 5'd7);
    step();
    req_valid = 1'b0;
    step();
    chk("lbu_rsp_rdata", rsp_rdata, 32'h00000088);
    chk("lbu_rsp_rd", 32'(rsp_rd), 32'd7);
    step();

    // Invalid load funct3 = 011 and invalid store funct3 = 100
    acc_base = acc_cnt;
    set_req(1'b1, 3'b011, 32'h10, 32'h0, 5'd3);
    step();
    req_valid = 1'b0;
    chk("badld_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("badld_rsp_err", 32'(rsp_err), 32'd1);
    chk("badld_rsp_rdata", rsp_rdata, 32'h0);
    chk("badld_ld_code", 32'(mem_load_code), 32'h7);
    step();
    chk("badld_done_ready", 32'(req_ready), 32'd1);
    set_req(1'b0, 3'b100, 32'h30, 32'h12345678, 5'd0);
    step();
    req_valid = 1'b0;
    chk("badst_rsp_err", 32'(rsp_err), 32'd1);
    step();
    chk("bad_no_access", 32'(acc_cnt - acc_base), 32'd0);
    chk("bad_addr_untouched", mem_addr, 32'h20);

    // Misaligned word load
    acc_base = acc_cnt;
    set_req(1'b1, 3'b010, 32'h13, 32'h0, 5'd8);
    step();
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mis_rsp_err", 32'(rsp_err), 32'd1);
    step();
    chk("mis_no_access", 32'(acc_cnt - acc_base), 32'd0);
`else
    chk("mis_issue_addr", mem_addr, 32'h13);
    chk("mis_issue_ld_code", 32'(mem_load_code), 32'h2);
    step();
    chk("mis_rsp_err", 32'(rsp_err), 32'd0);
    chk("mis_rsp_rdata", rsp_rdata, 32'h000000DE);
    step();
    chk("mis_access", 32'(acc_cnt - acc_base), 32'd1);
`endif

    // Reset while a load response is pending
    rsp_ready = 1'b0;
    set_req(1'b1, 3'b010, 32'h10, 32'h0, 5'd9);
    step();
    req_valid = 1'b0;
    step();
    chk("rr_pre_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_valid", 32'(rsp_valid), 32'd0);
    chk("rr_ld_code", 32'(mem_load_code), 32'h7);
    chk("rr_st_code", 32'(mem_store_code), 32'h3);
    chk("rr_req_ready", 32'(req_ready), 32'd1);
    #1;
    rst = 1'b0;
    step();
    chk("rr_after_ready", 32'(req_ready), 32'd1);
    chk("rr_after_valid", 32'(rsp_valid), 32'd0);

    // Reset during ISSUE drops the op
    rsp_ready = 1'b1;
    set_req(1'b1, 3'b010, 32'h10, 32'h0, 5'd10);
    step();
    req_valid = 1'b0;
    chk("ri_issue_ld_code", 32'(mem_load_code), 32'h2);
    rst = 1'b1;
    #1;
    chk("ri_ld_code", 32'(mem_load_code), 32'h7);
    chk("ri_mem_addr", mem_addr, 32'h0);
    #1;
    rst = 1'b0;
    step();
    chk("ri_no_rsp_a", 32'(rsp_valid), 32'd0);
    step();
    chk("ri_no_rsp_b", 32'(rsp_valid), 32'd0);
    chk("ri_ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
